// File: rtl/fpu_pkg.sv
// Package: fpu_pkg
// Shared definitions for the FPU operand stream: opcode encodings, default
// widths, the response record and a pointer-width helper for the FIFO.
package fpu_pkg;

    localparam int FPU_DATA_W = 32;
    localparam int FPU_OP_W   = 2;
    localparam int FPU_TAG_W  = 4;

    typedef enum logic [FPU_OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;

    typedef struct packed {
        logic [FPU_DATA_W-1:0] data;
        logic [FPU_TAG_W-1:0]  tag;
    } fpu_rsp_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fpu_stream_adapter_if.sv
// Interface: fpu_stream_adapter_if
// Request (operands, opcode, tag) and response (result, tag) valid/ready
// channels of the FPU operand stream. The master drives requests and accepts
// responses; the slave is the adapter.
interface fpu_stream_adapter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 2,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/fpu_adapt_fifo.sv
// Module: fpu_adapt_fifo
// Synchronous response FIFO. Power-of-two depth so the read/write pointers
// wrap naturally; count is one bit wider than the pointers so full and empty
// are distinguishable. Storage is not reset, only pointers and count.
module fpu_adapt_fifo
    import fpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 36,
    localparam int AW    = fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Next pointers and occupancy; push+pop together leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // The credit scheme upstream must never let a push land on a full FIFO.
    always @(posedge clk) begin
        if (!rst) assert (!(push && !pop && (count_q == (AW+1)'(DEPTH))));
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fpu_stream_adapter.sv
// Module: fpu_stream_adapter
// Responder side of the FPU operand stream. Registers accepted operands onto
// the fpu inputs, tracks each request's valid/tag through a shift pipe that
// matches the fpu latency, captures fpu_out into a response FIFO and returns
// results in accept order. A request is accepted only when a FIFO slot is
// guaranteed (queued + in-flight < depth), so no result is ever dropped.
// Optional build macro: FPU_ADAPT_STATS_EN enables the accept/stall counters;
// without it stat_acc/stat_stall are tied to zero.
module fpu_stream_adapter
    import fpu_pkg::*;
#(
    parameter int DATA_W     = FPU_DATA_W,
    parameter int OP_W       = FPU_OP_W,
    parameter int TAG_W      = FPU_TAG_W,
    parameter int FPU_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    fpu_stream_adapter_if.slave stream,
    output logic [DATA_W-1:0] fpu_a,
    output logic [DATA_W-1:0] fpu_b,
    output logic [OP_W-1:0]   fpu_op,
    input  logic [DATA_W-1:0] fpu_out,
    output logic [15:0]       stat_acc,
    output logic [15:0]       stat_stall
);

    // One stage parallel to the fpu input registers plus FPU_LAT stages for
    // the core itself: the last stage lines up with a valid fpu_out.
    localparam int PIPE_N = FPU_LAT + 1;
    localparam int AW     = fifo_ptr_w(FIFO_DEPTH);
    localparam int FW     = DATA_W + TAG_W;
    localparam logic [AW+1:0] CREDITS = (AW+2)'(FIFO_DEPTH);

    logic              accept;
    logic [DATA_W-1:0] fpu_a_q, fpu_a_d;
    logic [DATA_W-1:0] fpu_b_q, fpu_b_d;
    logic [OP_W-1:0]   fpu_op_q, fpu_op_d;
    logic [PIPE_N-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]  pipe_tag_q [PIPE_N];
    logic [TAG_W-1:0]  pipe_tag_d [PIPE_N];
    logic [AW+1:0]     inflight;
    logic [AW+1:0]     used;
    logic [AW:0]       fifo_count;
    logic              fifo_push;
    logic              fifo_pop;
    logic [FW-1:0]     fifo_head;

    assign accept = stream.req_valid && stream.req_ready;

    // Credit check from registered state only: queued plus in-flight results.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_N; i++) begin
            inflight = inflight + (AW+2)'(pipe_vld_q[i]);
        end
        used             = inflight + (AW+2)'(fifo_count);
        stream.req_ready = !rst && (used < CREDITS);
    end

    // Operand capture on accept and valid/tag shift toward the FIFO.
    always_comb begin
        fpu_a_d       = accept ? stream.req_a  : fpu_a_q;
        fpu_b_d       = accept ? stream.req_b  : fpu_b_q;
        fpu_op_d      = accept ? stream.req_op : fpu_op_q;
        pipe_vld_d    = {pipe_vld_q[PIPE_N-2:0], accept};
        pipe_tag_d[0] = stream.req_tag;
        for (int i = 1; i < PIPE_N; i++) begin
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    // fpu input registers and pipe valids; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a_q    <= '0;
            fpu_b_q    <= '0;
            fpu_op_q   <= '0;
            pipe_vld_q <= '0;
        end else begin
            fpu_a_q    <= fpu_a_d;
            fpu_b_q    <= fpu_b_d;
            fpu_op_q   <= fpu_op_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end

    // Tags ride along with the valids; qualified by pipe_vld_q, so no reset.
    always_ff @(posedge clk) begin
        pipe_tag_q <= pipe_tag_d;
    end

    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign fifo_push = pipe_vld_q[PIPE_N-1];
    assign fifo_pop  = stream.rsp_valid && stream.rsp_ready;

    fpu_adapt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({fpu_out, pipe_tag_q[PIPE_N-1]}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign stream.rsp_valid = (fifo_count != '0);
    assign stream.rsp_data  = fifo_head[FW-1:TAG_W];
    assign stream.rsp_tag   = fifo_head[TAG_W-1:0];

`ifdef FPU_ADAPT_STATS_EN
    logic [15:0] stat_acc_q, stat_acc_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating accept and stalled-request counters.
    always_comb begin
        stat_acc_d   = accept ? sat_inc16(stat_acc_q) : stat_acc_q;
        stat_stall_d = (stream.req_valid && !stream.req_ready) ?
                       sat_inc16(stat_stall_q) : stat_stall_q;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_acc_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_acc_q   <= stat_acc_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_acc   = stat_acc_q;
    assign stat_stall = stat_stall_q;
`else
    assign stat_acc   = 16'h0000;
    assign stat_stall = 16'h0000;
`endif

endmodule
